// File: rtl/cmp_pipe.sv
// ---------------------------------------------------------------------------
// cmp_pipe
// Pipelined condition comparator for the execute stage. It resolves branch
// conditions and SLT/min/max style ALU results. Each request {op, a, b, tag}
// is accepted over a valid/ready handshake. The flag, value, tag and illegal
// bit come out exactly STAGES cycles later when nothing downstream stalls.
//
// Parameters:
//   XLEN   operand/result width (8..64), defaults to `XLEN (32)
//   STAGES pipeline depth = latency in cycles (1..4)
//   TAG_W  width of the opaque tag carried with each op
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   flush                 drop every in-flight op this cycle
//   in_valid/in_ready     request handshake
//   in_op, in_a, in_b     opcode and operands
//   in_tag                opaque tag, returned with the result
//   out_valid/out_ready   result handshake
//   out_flag              condition result
//   out_value             zero-extended flag (compares) or chosen operand
//   out_tag               tag of the result
//   out_illegal           opcode was not recognised
//
// Optional feature (macro CMP_PIPE_MINMAX_EN):
//   Defined   -> ops 8..11 (MIN/MAX/MINU/MAXU) select an operand.
//   Undefined -> ops 8..11 are illegal, and the operand pipeline and
//                the selection mux are not built.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module cmp_pipe #(
  parameter int XLEN   = `XLEN,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_flag,
  output logic [XLEN-1:0]  out_value,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [3:0] OP_EQ    = 4'd0;
  localparam logic [3:0] OP_NE    = 4'd1;
  localparam logic [3:0] OP_LT    = 4'd2;
  localparam logic [3:0] OP_LTU   = 4'd3;
  localparam logic [3:0] OP_GE    = 4'd4;
  localparam logic [3:0] OP_GEU   = 4'd5;
  localparam logic [3:0] OP_TRUE  = 4'd6;
  localparam logic [3:0] OP_FALSE = 4'd7;
`ifdef CMP_PIPE_MINMAX_EN
  localparam logic [3:0] OP_MIN   = 4'd8;
  localparam logic [3:0] OP_MAX   = 4'd9;
  localparam logic [3:0] OP_MINU  = 4'd10;
  localparam logic [3:0] OP_MAXU  = 4'd11;
`endif

  logic             adv_out;
  logic             s1_adv;
  logic             accept;

  // The view of the op that feeds the final decode and the output register
  logic             d_valid;
  logic [3:0]       d_op;
  logic [TAG_W-1:0] d_tag;
  logic             d_eq;
  logic             d_lt;
  logic             d_ltu;
`ifdef CMP_PIPE_MINMAX_EN
  logic [XLEN-1:0]  d_a;
  logic [XLEN-1:0]  d_b;
`endif

  logic             n_flag;
  logic [XLEN-1:0]  n_value;
  logic             n_illegal;
  logic             n_is_cmp;

  assign adv_out  = !out_valid || out_ready;
  assign in_ready = s1_adv && !flush;
  assign accept   = in_valid && in_ready;

  generate
    if (STAGES == 1) begin : g_single
      // With one stage the compare and decode both feed the output register
      assign s1_adv  = adv_out;
      assign d_valid = accept;
      assign d_op    = in_op;
      assign d_tag   = in_tag;
      assign d_eq    = (in_a == in_b);
      assign d_lt    = ($signed(in_a) < $signed(in_b));
      assign d_ltu   = (in_a < in_b);
`ifdef CMP_PIPE_MINMAX_EN
      assign d_a     = in_a;
      assign d_b     = in_b;
`endif
    end else begin : g_multi
      localparam int P = STAGES - 1;

      logic [P:1]       pv;
      logic [P:1]       peq;
      logic [P:1]       plt;
      logic [P:1]       pltu;
      logic [3:0]       pop  [1:P];
      logic [TAG_W-1:0] ptag [1:P];
`ifdef CMP_PIPE_MINMAX_EN
      logic [XLEN-1:0]  pa   [1:P];
      logic [XLEN-1:0]  pb   [1:P];
`endif
      logic [P:1]       adv;

      // A stage may move when the output drains or any later stage has a hole
      for (genvar k = 1; k <= P; k++) begin : g_adv
        assign adv[k] = adv_out || !(&pv[P:k]);
      end

      assign s1_adv = adv[1];

      // Stage valid bits; flush wins over both accept and stall
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
        end else if (flush) begin
          pv <= '0;
        end else begin
          if (adv[1]) pv[1] <= accept;
          for (int k = 2; k <= P; k++) begin
            if (adv[k]) pv[k] <= pv[k-1];
          end
        end
      end

      // Stage 1 does all comparisons; later stages only delay the results
      always_ff @(posedge clk) begin
        if (accept) begin
          pop[1]  <= in_op;
          ptag[1] <= in_tag;
          peq[1]  <= (in_a == in_b);
          plt[1]  <= ($signed(in_a) < $signed(in_b));
          pltu[1] <= (in_a < in_b);
`ifdef CMP_PIPE_MINMAX_EN
          pa[1]   <= in_a;
          pb[1]   <= in_b;
`endif
        end
        for (int k = 2; k <= P; k++) begin
          if (!flush && adv[k] && pv[k-1]) begin
            pop[k]  <= pop[k-1];
            ptag[k] <= ptag[k-1];
            peq[k]  <= peq[k-1];
            plt[k]  <= plt[k-1];
            pltu[k] <= pltu[k-1];
`ifdef CMP_PIPE_MINMAX_EN
            pa[k]   <= pa[k-1];
            pb[k]   <= pb[k-1];
`endif
          end
        end
      end

      assign d_valid = pv[P];
      assign d_op    = pop[P];
      assign d_tag   = ptag[P];
      assign d_eq    = peq[P];
      assign d_lt    = plt[P];
      assign d_ltu   = pltu[P];
`ifdef CMP_PIPE_MINMAX_EN
      assign d_a     = pa[P];
      assign d_b     = pb[P];
`endif
    end
  endgenerate

  // Decode the flag and value from the registered compare bits; ties in
  // min/max pick a because the strict less-than selects b only when b wins
  always_comb begin
    n_flag    = 1'b0;
    n_value   = '0;
    n_illegal = 1'b0;
    n_is_cmp  = 1'b1;
    case (d_op)
      OP_EQ:    n_flag = d_eq;
      OP_NE:    n_flag = !d_eq;
      OP_LT:    n_flag = d_lt;
      OP_LTU:   n_flag = d_ltu;
      OP_GE:    n_flag = !d_lt;
      OP_GEU:   n_flag = !d_ltu;
      OP_TRUE:  n_flag = 1'b1;
      OP_FALSE: n_flag = 1'b0;
`ifdef CMP_PIPE_MINMAX_EN
      OP_MIN: begin
        n_is_cmp = 1'b0;
        n_flag   = d_lt;
        n_value  = d_lt ? d_a : d_b;
      end
      OP_MAX: begin
        n_is_cmp = 1'b0;
        n_flag   = d_lt;
        n_value  = d_lt ? d_b : d_a;
      end
      OP_MINU: begin
        n_is_cmp = 1'b0;
        n_flag   = d_ltu;
        n_value  = d_ltu ? d_a : d_b;
      end
      OP_MAXU: begin
        n_is_cmp = 1'b0;
        n_flag   = d_ltu;
        n_value  = d_ltu ? d_b : d_a;
      end
`endif
      default: begin
        n_is_cmp  = 1'b0;
        n_illegal = 1'b1;
      end
    endcase
    if (n_is_cmp) n_value = {{(XLEN-1){1'b0}}, n_flag};
  end

  // Output register; data only loads with a real op so it holds under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_flag    <= 1'b0;
      out_value   <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv_out) begin
      out_valid <= d_valid;
      if (d_valid) begin
        out_flag    <= n_flag;
        out_value   <= n_value;
        out_tag     <= d_tag;
        out_illegal <= n_illegal;
      end
    end
  end

endmodule

// File: doc/cmp_pipe.md
Name: cmp_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle condition comparator; serves branch resolution and SLT/min/max-style ALU ops in the execute stage.
- Accepts one {op, a, b, tag} per cycle over a valid/ready handshake.
- Produces a 1-bit condition flag and an XLEN-bit value after a fixed STAGES-cycle latency.
- Supports full backpressure and a same-cycle pipeline flush for mispredict/trap recovery.

Parameters:
- XLEN, default `XLEN (32), operand/result width; legal 8..64.
- STAGES, default 2, pipeline depth = latency in cycles; legal 1..4.
- TAG_W, default 5, width of the opaque tag carried alongside each op.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard every in-flight op this cycle.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  4  opcode: 0 EQ, 1 NE, 2 LT, 3 LTU, 4 GE, 5 GEU, 6 TRUE, 7 FALSE, 8 MIN, 9 MAX, 10 MINU, 11 MAXU; 12..15 illegal.
- in_a  in  XLEN  operand A.
- in_b  in  XLEN  operand B.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_flag  out  1  condition result.
- out_value  out  XLEN  compare ops: zero-extended out_flag; min/max ops: selected operand.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  op was illegal.

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits = 0. out_valid = 0, out_flag = 0, out_value = 0, out_tag = 0, out_illegal = 0. in_ready = 1 after rst_n deasserts (with flush low).
- Stage 1:
  - Registers eq = (a == b), lt = signed a < signed b, ltu = unsigned a < unsigned b.
  - Also registers op, a, b, tag.
  - Flag is decoded from registered eq/lt/ltu; no comparison logic after stage 1.
- Stages 2..STAGES: pure delay registers. Final decode/select feeds the last stage register, so all out_* are registered.
- Flag decode: EQ eq; NE !eq; LT lt; LTU ltu; GE !lt; GEU !ltu; TRUE 1; FALSE 0.
- MIN/MAX/MINU/MAXU: out_flag = selecting comparison (lt or ltu); out_value = the chosen operand. Ties return a.
- Illegal op: out_flag = 0, out_value = 0, out_illegal = 1. The op still flows, is handshaken normally, and its tag is preserved.
- Latency: an op accepted in cycle N is presented with out_valid = 1 in cycle N+STAGES when there is no backpressure.
- Throughput: 1 op/cycle.
- Backpressure, per stage k:
  - adv[k] = !v[k] || adv[k+1], with adv[STAGES] = !v[last] || out_ready.
  - in_ready = adv[1] && !flush; it never depends combinationally on in_valid.
  - A stalled stage holds all its fields stable.
  - out_* stay stable while out_valid && !out_ready.
- Flush: all v[k] cleared at the next edge. in_ready = 0 during the flush cycle, so nothing is accepted. out_valid = 0 the cycle after. Data registers may keep stale values. Flush has priority over accept and over stall.
- Simultaneous output pop and input push on a full pipeline: allowed, no bubble.
- Reset mid-operation: all in-flight ops are lost; no output is produced for them.
- Wrap-around and width: comparisons use the full XLEN. Signed compare treats bit XLEN-1 as the sign: 0x8000_0000 < 0x7FFF_FFFF signed, > unsigned.

Optional Feature:
- Macro: CMP_PIPE_MINMAX_EN.
- Defined: ops 8..11 behave as above.
- Undefined: ops 8..11 are treated as illegal (out_flag 0, out_value 0, out_illegal 1), and the min/max operand mux is not synthesised.

Test Plan:
- Reset + single ops, STAGES=2:
  - EQ a=5 b=5 -> out_flag=1, out_value=1, two cycles after accept.
  - LT a=0xFFFF_FFFF b=1 -> flag 1.
  - LTU with the same operands -> flag 0.
- Streaming: 16 back-to-back ops with out_ready=1 -> 16 results in order, tags 0..15, one per cycle, no bubbles.
- Backpressure:
  - out_ready=0 for 5 cycles with in_valid held -> in_ready drops once STAGES ops are buffered.
  - Outputs stay stable; no op is lost or duplicated after out_ready returns.
- Flush: 2 ops in flight, flush pulsed with in_valid=1 -> no out_valid for any of them, in_ready=0 that cycle; the next op issues normally with latency STAGES.
- MINMAX with the macro defined:
  - MIN a=0x8000_0000 b=3 -> value 0x8000_0000.
  - MINU -> 3.
  - MAX a=b=7 -> value 7, flag 0.
  - Macro undefined: op 8 -> out_illegal=1, value 0.
- Async reset asserted mid-stream with 2 ops in flight -> out_valid=0 immediately (no clock edge needed); nothing emitted after release.
